// File: rtl/cla_carry_pipe.sv
// Two-stage carry-lookahead front end: stage 1 forms bit and group propagate/generate,
// stage 2 resolves group carry-ins and per-bit carries. Valid/ready on both sides.
module cla_carry_pipe #(
  parameter int WIDTH = 17,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] c_out,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  // Handshake: a beat moves across a boundary in a cycle where the sender's valid and
  // the receiver's ready are both 1 at the rising edge; in_ready does not depend on in_valid.

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] r_g1;
  logic [NG-1:0]    r_gp1;
  logic [NG-1:0]    r_gg1;
  logic             r_cin1;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_p_out;
  logic [WIDTH-1:0] r_c_out;
  logic             r_cout;
  logic             r_ovf;

  logic             w_adv1;
  logic             w_adv2;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [WIDTH-1:0] w_c;
  logic             w_cout;

  assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_adv1   = in_valid & in_ready;

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;
  assign w_p       = a ^ w_b_eff;
  assign w_g       = a & w_b_eff;

  // Group terms built LSB-first so the last group may be narrower than GROUP.
  always_comb begin
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    gp = '1;
    gg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gg[i / GROUP] = w_g[i] | (w_p[i] & gg[i / GROUP]);
      gp[i / GROUP] = gp[i / GROUP] & w_p[i];
    end
    w_gp = gp;
    w_gg = gg;
  end

  always_comb begin
    logic [NG:0] cg;
    logic [WIDTH-1:0] cv;
    logic c;
    cg    = '0;
    cg[0] = r_cin1;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = r_gg1[k] | (r_gp1[k] & cg[k]);
    end
    cv = '0;
    c  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GROUP == 0) c = cg[i / GROUP];
      cv[i] = c;
      c     = r_g1[i] | (r_p1[i] & c);
    end
    w_c    = cv;
    w_cout = cg[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_p1       <= '0;
      r_g1       <= '0;
      r_gp1      <= '0;
      r_gg1      <= '0;
      r_cin1     <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= 1'b1;
        r_p1       <= w_p;
        r_g1       <= w_g;
        r_gp1      <= w_gp;
        r_gg1      <= w_gg;
        r_cin1     <= w_cin_eff;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_p_out    <= '0;
      r_c_out    <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= 1'b1;
        r_p_out    <= r_p1;
        r_c_out    <= w_c;
        r_cout     <= w_cout;
        r_ovf      <= w_c[WIDTH-1] ^ w_cout;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign p_out     = r_p_out;
  assign c_out     = r_c_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Bench for cla_carry_pipe: directed cases, backpressure, mid-flight reset and a
// randomized run scored against an arithmetic model of the add/subtract result.
module tb_cla_carry_pipe;

  localparam int W  = 17;
  localparam int EW = 2 * W + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p_out;
  logic [W-1:0] c_out;
  logic         cout;
  logic         ovf;

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_err;
  logic          last_acc;
  int            n_pop;
  logic [EW-1:0] snap;

  cla_carry_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .c_out(c_out), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit addition; carries into each bit are sum ^ a ^ b_eff.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                          input logic ci, input logic si);
    logic [W-1:0] be;
    logic [W:0]   s;
    logic [W-1:0] p;
    logic         o;
    be = si ? ~bi : bi;
    s  = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, (si | ci)};
    p  = ai ^ be;
    o  = (ai[W-1] == be[W-1]) && (s[W-1] != ai[W-1]);
    return {p, s[W-1:0] ^ p, s[W], o};
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        last_acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", EW'(1), EW'(0));
        end else begin
          chk("beat", {p_out, c_out, cout, ovf}, exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    sub      = si;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input logic si, input logic [EW-1:0] expv,
                          input logic [W-1:0] sum);
    drive(1'b1, ai, bi, ci, si);
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk({tag, "_lat1"}, EW'(out_valid), EW'(0));
    tick();
    chk({tag, "_valid"}, EW'(out_valid), EW'(1));
    chk({tag, "_fields"}, {p_out, c_out, cout, ovf}, expv);
    chk({tag, "_sum"}, EW'(c_out ^ p_out), EW'(sum));
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    n_pop    = 0;
    last_acc = 1'b0;
    rst      = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_outputs", {p_out, c_out, cout, ovf}, EW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", EW'(in_ready), EW'(1));

    // p, c_out, cout, ovf constants
    directed("add_prop", 17'h1FFFF, 17'h00001, 1'b0, 1'b0,
             {17'h1FFFE, 17'h1FFFE, 1'b1, 1'b0}, 17'h00000);
    directed("sub_borrow", 17'h00005, 17'h00007, 1'b0, 1'b1,
             {17'h1FFFD, 17'h00003, 1'b0, 1'b0}, 17'h1FFFE);
    directed("signed_ovf", 17'h0FFFF, 17'h00001, 1'b0, 1'b0,
             {17'h0FFFE, 17'h1FFFE, 1'b0, 1'b1}, 17'h10000);
    chk("directed_drained", EW'(exp_q.size()), EW'(0));

    // Backpressure: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    drive(1'b1, 17'h00123, 17'h00456, 1'b1, 1'b0);
    #1;
    chk("bp_ready_b1", EW'(in_ready), EW'(1));
    tick();
    drive(1'b1, 17'h1F000, 17'h00FFF, 1'b0, 1'b1);
    #1;
    chk("bp_ready_b2", EW'(in_ready), EW'(1));
    tick();
    drive(1'b1, 17'h0AAAA, 17'h15555, 1'b1, 1'b0);
    #1;
    chk("bp_full_ready", EW'(in_ready), EW'(0));
    chk("bp_out_valid", EW'(out_valid), EW'(1));
    snap = {p_out, c_out, cout, ovf};
    tick();
    chk("bp_no_accept", EW'(last_acc), EW'(0));
    tick();
    chk("bp_hold_valid", EW'(out_valid), EW'(1));
    chk("bp_hold_data", {p_out, c_out, cout, ovf}, snap);
    chk("bp_queued", EW'(exp_q.size()), EW'(2));
    out_ready = 1'b1;
    n_pop = 0;
    tick();
    chk("bp_b3_accept", EW'(last_acc), EW'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_drain2_valid", EW'(out_valid), EW'(1));
    tick();
    chk("bp_drain3_valid", EW'(out_valid), EW'(1));
    tick();
    chk("bp_drained", EW'(out_valid), EW'(0));
    chk("bp_pop_count", EW'(n_pop), EW'(3));
    chk("bp_queue_empty", EW'(exp_q.size()), EW'(0));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive(1'b1, 17'h01234, 17'h00F0F, 1'b0, 1'b0);
    tick();
    drive(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", EW'(out_valid), EW'(0));
    chk("mid_rst_outputs", {p_out, c_out, cout, ovf}, EW'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", EW'(in_ready), EW'(1));
    out_ready = 1'b1;
    n_pop = 0;
    repeat (4) tick();
    chk("no_stale_beat", EW'(n_pop), EW'(0));

    // Randomized regression; inputs only change once the offered beat is taken.
    n_pop = 0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20000; i++) begin
      if (!in_valid || last_acc) begin
        drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_queue_empty", EW'(exp_q.size()), EW'(0));
    chk("rand_idle", EW'(out_valid), EW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
